rvc_fetch_sequencer: RTL and testbench
======================================

# rvc_fetch_sequencer

Fetch-side producer for the IF stage with C-extension support. It generates word-aligned instruction-memory reads and buffers returned words as a queue of 16-bit parcels. It emits one complete instruction per handshake (16-bit compressed or 32-bit, including 32-bit instructions spanning two words) together with its PC. It handles redirects to word- or halfword-aligned targets, replacing ad-hoc spanning/buffer flags with a single parcel queue.

## Interface
- XLEN, 32, address/PC width
- RESET_PC, 32'h0000_0000, first fetch target after reset (bit 0 must be 0)
- QUEUE_PARCELS, 8, parcel queue depth; power of two, minimum 8
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- o_imem_req  out  1  read request this cycle
- o_imem_addr  out  XLEN  word-aligned read address, bits [1:0] always 0
- i_imem_rdata  in  32  read data, valid exactly one cycle after an accepted request
- i_redirect  in  1  flush and restart fetch at i_redirect_pc
- i_redirect_pc  in  XLEN  redirect target; bit 0 ignored
- o_instr_valid  out  1  o_instr/o_instr_pc/o_is_compressed valid
- i_instr_ready  in  1  consumer accepts the instruction
- o_instr  out  32  instruction; compressed parcels in [15:0] with [31:16]=0
- o_instr_pc  out  XLEN  PC of o_instr
- o_is_compressed  out  1  o_instr[1:0] != 2'b11

## Operation
- Memory accepts every request. Data for a request in cycle N appears in N+1. A response is pending in cycle N+1 iff o_imem_req was high in cycle N.
- Queue count c is in parcels. The pending flag p is a register. Issue request iff c + 2p <= QUEUE_PARCELS-4 and !i_redirect.
- After each request, fetch address advances by 4, modulo 2^XLEN (wraps to 0).
- On a response, push the low parcel, then the high parcel. If skip_lo is set, drop the low parcel and clear skip_lo.
- Head parcel compressed: o_instr_valid needs c>=1. Head parcel 32-bit: o_instr_valid needs c>=2, with o_instr = {parcel1, parcel0}.
- On handshake, pop 1 or 2 parcels and advance o_instr_pc by 2 or 4.
- A push and a pop in the same cycle are both applied.
- Redirect in cycle N, with priority over handshake and response:
  - Clear the queue. Drop the response arriving in cycle N.
  - Load the fetch address with {pc[XLEN-1:2],2'b00} and o_instr_pc with {pc[XLEN-1:1],1'b0}.
  - Set skip_lo = pc[1].
  - Force o_instr_valid=0 and o_imem_req=0 in cycle N.
- Reset values:
  - o_imem_req=0, o_instr_valid=0, o_instr=0, o_is_compressed=0.
  - o_imem_addr = RESET_PC with [1:0] cleared; o_instr_pc = RESET_PC.
  - c=0, p=0, skip_lo=RESET_PC[1].
- Reset asserted mid-stream discards all queue contents and the pending response.

## Timing
- Reset deassert edge → o_imem_req=1 in the next cycle → data one cycle later → o_instr_valid in the following cycle, so 3 cycles after deassert.
- Redirect in cycle N: request in N+1, response in N+2, o_instr_valid earliest in N+3. A halfword target whose head is a 32-bit instruction adds one fetch.
- Steady state: one 32-bit instruction per cycle with i_instr_ready held high.
- o_instr_valid, o_instr and o_is_compressed derive combinationally from queue registers only, with no path from i_instr_ready.
- o_imem_req depends combinationally on i_redirect only.

## Configuration
- FROST_RVC_EN defined: behaviour as above.
- FROST_RVC_EN undefined:
  - o_is_compressed is tied to 0; every instruction pops two parcels; o_instr_pc advances by 4.
  - i_redirect_pc[1] is treated as 0 and skip_lo is removed.

## Structure
- Shared if_stage package:
  - parcel_t (16-bit) typedef.
  - QUEUE_PARCELS default.
  - is_compressed(parcel) function, also used by the decompressor.
- Sub-module parcel_fifo:
  - Circular buffer with dual push (0/1/2 parcels) and dual pop (0/1/2 parcels).
  - Exposes head two entries and count.
  - Synchronous clear.

## Test plan
- Reset with RESET_PC=0x100, memory returns 0x00000013 at 0x100 and 0x00100093 at 0x104, ready=1 → valid at cycle 3; PC 0x100, then PC 0x104, both 32-bit.
- Word 0x4505_4501 (two c.li) → PC 0x0 compressed o_instr=0x00004501, then PC 0x2 o_instr=0x00004505.
- Word0 = {0x0513, 0x4501}, word1 = {xxxx, 0x0000} → compressed at 0x0, then spanning 32-bit at 0x2 with o_instr=0x00000513.
- Redirect to 0x202 while queue full and response arriving → response dropped, request at 0x200 next cycle, first instruction PC 0x202 from bits [31:16].
- i_instr_ready=0 for 10 cycles → requests stop once c+2p>QUEUE_PARCELS-4; no overflow; o_instr stable; resume without loss.
- Fetch address at 0xFFFF_FFFC → next request wraps to 0x0000_0000.

Source files
------------

// File: rtl/rvc_fetch_sequencer_pkg.sv
// Shared IF-stage types: the 16-bit parcel, the default parcel-queue depth and the
// compressed-parcel test, which the decompressor uses as well.
package rvc_fetch_sequencer_pkg;

   typedef logic [15:0] parcel_t;

   localparam int unsigned QUEUE_PARCELS_DEF = 8;

   function automatic logic is_compressed(input parcel_t p);
      return p[1:0] != 2'b11;
   endfunction

endpackage

// File: rtl/rvc_fetch_sequencer_parcel_fifo.sv
// Circular parcel buffer with 0/1/2-parcel push and pop per cycle, a synchronous
// clear, and the two head entries exposed for instruction assembly.
module rvc_fetch_sequencer_parcel_fifo
   import rvc_fetch_sequencer_pkg::*;
#(
   parameter int unsigned DEPTH = QUEUE_PARCELS_DEF
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       clr_i,
   input  logic [1:0]                 push_n_i,
   input  parcel_t                    push0_i,
   input  parcel_t                    push1_i,
   input  logic [1:0]                 pop_n_i,
   output parcel_t                    head0_o,
   output parcel_t                    head1_o,
   output logic [$clog2(DEPTH):0]     count_o
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   parcel_t       mem_q [DEPTH];

   always_comb begin
      rd_d  = rd_q + AW'(pop_n_i);
      wr_d  = wr_q + AW'(push_n_i);
      cnt_d = cnt_q + CW'(push_n_i) - CW'(pop_n_i);
      if (clr_i) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage carries no reset; the pointers alone decide what is live.
   always_ff @(posedge clk_i) begin
      if (push_n_i != 2'd0) mem_q[wr_q] <= push0_i;
      if (push_n_i == 2'd2) mem_q[wr_q + AW'(1)] <= push1_i;
   end

   assign head0_o = mem_q[rd_q];
   assign head1_o = mem_q[rd_q + AW'(1)];
   assign count_o = cnt_q;

endmodule

// File: rtl/rvc_fetch_sequencer.sv
// IF-stage fetch sequencer: word reads into a parcel queue, one whole instruction per
// handshake. Compressed (RVC) support is compiled in when FROST_RVC_EN is defined.
module rvc_fetch_sequencer
   import rvc_fetch_sequencer_pkg::*;
#(
   parameter int unsigned     XLEN          = 32,
   parameter logic [XLEN-1:0] RESET_PC      = '0,
   parameter int unsigned     QUEUE_PARCELS = QUEUE_PARCELS_DEF
) (
   input  logic            i_clk,
   input  logic            i_rst,
   output logic            o_imem_req,
   output logic [XLEN-1:0] o_imem_addr,
   input  logic [31:0]     i_imem_rdata,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic            o_instr_valid,
   input  logic            i_instr_ready,
   output logic [31:0]     o_instr,
   output logic [XLEN-1:0] o_instr_pc,
   output logic            o_is_compressed
);
   localparam int unsigned CW = $clog2(QUEUE_PARCELS) + 1;

   logic            running_q;
   logic            pend_q, pend_d;
   logic [XLEN-1:0] faddr_q, faddr_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            skip_lo;
   parcel_t         head0, head1, push0, push1;
   logic [CW-1:0]   count;
   logic [CW:0]     occ;
   logic [1:0]      push_n, pop_n;
   logic            head_c, q_valid, resp, hs;
   logic            unused_pc_bits;

   assign unused_pc_bits = ^i_redirect_pc[1:0];

`ifdef FROST_RVC_EN
   logic skip_q, skip_d;

   always_comb begin
      skip_d = skip_q;
      if (i_redirect)  skip_d = i_redirect_pc[1];
      else if (resp)   skip_d = 1'b0;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) skip_q <= RESET_PC[1];
      else       skip_q <= skip_d;
   end

   assign skip_lo = skip_q;
   assign head_c  = is_compressed(head0);
`else
   assign skip_lo = 1'b0;
   assign head_c  = 1'b0;
`endif

   // A pending response still needs two parcel slots, so it counts against free space.
   assign occ        = (CW+1)'(count) + (CW+1)'({pend_q, 1'b0});
   assign o_imem_req = running_q & ~i_redirect & (occ <= (CW+1)'(QUEUE_PARCELS - 4));

   assign q_valid         = head_c ? (count >= CW'(1)) : (count >= CW'(2));
   assign o_instr_valid   = q_valid & ~i_redirect;
   assign o_is_compressed = q_valid & head_c;
   assign hs              = o_instr_valid & i_instr_ready;

   always_comb begin
      o_instr = '0;
      if (q_valid) o_instr = head_c ? {16'h0000, head0} : {head1, head0};
   end

   assign resp   = pend_q & ~i_redirect;
   assign push_n = resp ? (skip_lo ? 2'd1 : 2'd2) : 2'd0;
   assign push0  = skip_lo ? i_imem_rdata[31:16] : i_imem_rdata[15:0];
   assign push1  = i_imem_rdata[31:16];
   assign pop_n  = hs ? (head_c ? 2'd1 : 2'd2) : 2'd0;

   always_comb begin
      pend_d  = o_imem_req;
      faddr_d = faddr_q;
      pc_d    = pc_q;
      if (i_redirect) begin
         faddr_d = {i_redirect_pc[XLEN-1:2], 2'b00};
`ifdef FROST_RVC_EN
         pc_d    = {i_redirect_pc[XLEN-1:1], 1'b0};
`else
         pc_d    = {i_redirect_pc[XLEN-1:2], 2'b00};
`endif
      end else begin
         if (o_imem_req) faddr_d = faddr_q + XLEN'(4);
         if (hs)         pc_d    = pc_q + (head_c ? XLEN'(2) : XLEN'(4));
      end
   end

   // running_q holds off the first request until the cycle after reset release.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         running_q <= 1'b0;
         pend_q    <= 1'b0;
         faddr_q   <= {RESET_PC[XLEN-1:2], 2'b00};
         pc_q      <= RESET_PC;
      end else begin
         running_q <= 1'b1;
         pend_q    <= pend_d;
         faddr_q   <= faddr_d;
         pc_q      <= pc_d;
      end
   end

   assign o_imem_addr = faddr_q;
   assign o_instr_pc  = pc_q;

   rvc_fetch_sequencer_parcel_fifo #(
      .DEPTH (QUEUE_PARCELS)
   ) u_fifo (
      .clk_i    (i_clk),
      .rst_i    (i_rst),
      .clr_i    (i_redirect),
      .push_n_i (push_n),
      .push0_i  (push0),
      .push1_i  (push1),
      .pop_n_i  (pop_n),
      .head0_o  (head0),
      .head1_o  (head1),
      .count_o  (count)
   );

endmodule

// File: tb/tb_rvc_fetch_sequencer.sv
// Bench for rvc_fetch_sequencer: directed scenarios then random ready/redirect traffic,
// checked against an architectural model that walks the instruction stream in memory.
module tb_rvc_fetch_sequencer;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic [31:0] i_imem_rdata;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;
   logic        o_instr_valid;
   logic        i_instr_ready;
   logic [31:0] o_instr;
   logic [31:0] o_instr_pc;
   logic        o_is_compressed;

   rvc_fetch_sequencer #(
      .XLEN          (32),
      .RESET_PC      (32'h0000_0100),
      .QUEUE_PARCELS (8)
   ) dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .o_imem_req      (o_imem_req),
      .o_imem_addr     (o_imem_addr),
      .i_imem_rdata    (i_imem_rdata),
      .i_redirect      (i_redirect),
      .i_redirect_pc   (i_redirect_pc),
      .o_instr_valid   (o_instr_valid),
      .i_instr_ready   (i_instr_ready),
      .o_instr         (o_instr),
      .o_instr_pc      (o_instr_pc),
      .o_is_compressed (o_is_compressed)
   );

   always #5 i_clk = ~i_clk;

   int          checks = 0;
   int          errors = 0;
   int          idle   = 0;
   logic [31:0] mpc;
   logic [31:0] exp_faddr;
   logic [31:0] ovr [logic [31:0]];
   logic        last_req, last_valid, last_comp;
   logic [31:0] last_addr, last_pc, last_instr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (ovr.exists(a)) return ovr[a];
      return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
   endfunction

   function automatic logic [15:0] hw(input logic [31:0] a);
      logic [31:0] w;
      w = mem_word({a[31:2], 2'b00});
      return a[1] ? w[31:16] : w[15:0];
   endfunction

   // One clock cycle: sample mid-cycle, check against the model, then advance at the edge.
   task automatic step();
      logic        rd, req, hs, ec;
      logic [31:0] tgt, addr, ei;
      logic [15:0] h0, h1;
      @(negedge i_clk);
      rd   = i_redirect;
      tgt  = i_redirect_pc;
      req  = o_imem_req;
      addr = o_imem_addr;
      last_req = req; last_addr = addr; last_valid = o_instr_valid;
      last_pc = o_instr_pc; last_instr = o_instr; last_comp = o_is_compressed;
      h0 = hw(mpc);
      h1 = hw(mpc + 32'd2);
`ifdef FROST_RVC_EN
      ec = (h0[1:0] != 2'b11);
`else
      ec = 1'b0;
`endif
      ei = ec ? {16'h0000, h0} : {h1, h0};
      if (rd) begin
         check("redir_req", 32'(req), 32'd0);
         check("redir_valid", 32'(o_instr_valid), 32'd0);
      end
      if (req) begin
         check("req_addr", addr, exp_faddr);
         exp_faddr = exp_faddr + 32'd4;
      end
      hs = 1'b0;
      if (o_instr_valid) begin
         check("instr_pc", o_instr_pc, mpc);
         check("instr", o_instr, ei);
         check("is_compressed", 32'(o_is_compressed), 32'(ec));
         hs = i_instr_ready;
      end
      if (o_instr_valid || rd) idle = 0;
      else begin
         idle++;
         if (idle == 8) check("starved_cycles", 32'(idle), 32'd0);
      end
      @(posedge i_clk);
      #1;
      if (rd) begin
`ifdef FROST_RVC_EN
         mpc = {tgt[31:1], 1'b0};
`else
         mpc = {tgt[31:2], 2'b00};
`endif
         exp_faddr = {tgt[31:2], 2'b00};
      end else if (hs) begin
         mpc = mpc + (ec ? 32'd2 : 32'd4);
      end
      i_imem_rdata = req ? mem_word(addr) : $urandom;
   endtask

   task automatic redirect_to(input logic [31:0] t);
      i_redirect    = 1'b1;
      i_redirect_pc = t;
      step();
      i_redirect    = 1'b0;
   endtask

   initial begin
      int n;
      i_rst = 1'b1; i_redirect = 1'b0; i_redirect_pc = '0;
      i_instr_ready = 1'b1; i_imem_rdata = '0;
      mpc = 32'h100; exp_faddr = 32'h100;
      ovr[32'h100] = 32'h0000_0013;
      ovr[32'h104] = 32'h0010_0093;
      ovr[32'h040] = 32'h4505_4501;
      ovr[32'h080] = 32'h0513_4501;
      ovr[32'h084] = 32'hABCD_0000;
      ovr[32'h200] = 32'h4505_4501;

      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      check("rst_req", 32'(o_imem_req), 32'd0);
      check("rst_valid", 32'(o_instr_valid), 32'd0);
      check("rst_instr", o_instr, 32'd0);
      check("rst_comp", 32'(o_is_compressed), 32'd0);
      check("rst_addr", o_imem_addr, 32'h100);
      check("rst_pc", o_instr_pc, 32'h100);
      @(posedge i_clk);
      #1 i_rst = 1'b0;

      // Reset release: first request next cycle, first instruction two cycles after that.
      step(); check("boot_req_idle", 32'(last_req), 32'd0);
      step(); check("boot_req", 32'(last_req), 32'd1);
      step(); check("boot_valid_early", 32'(last_valid), 32'd0);
      step(); check("boot_valid", 32'(last_valid), 32'd1);
      check("boot_pc0", last_pc, 32'h100);
      check("boot_instr0", last_instr, 32'h0000_0013);
      step(); check("boot_pc1", last_pc, 32'h104);
      check("boot_instr1", last_instr, 32'h0010_0093);

      // Two c.li in one word.
      redirect_to(32'h40);
      step(); check("cli_req_addr", last_addr, 32'h40);
      step(); check("cli_valid_early", 32'(last_valid), 32'd0);
      step(); check("cli_valid", 32'(last_valid), 32'd1);
`ifdef FROST_RVC_EN
      check("cli_instr0", last_instr, 32'h0000_4501);
      step(); check("cli_pc1", last_pc, 32'h42);
      check("cli_instr1", last_instr, 32'h0000_4505);
`else
      check("cli_instr0", last_instr, 32'h4505_4501);
      step(); check("cli_pc1", last_pc, 32'h44);
`endif

      // Compressed followed by a 32-bit instruction spanning two words.
      redirect_to(32'h80);
      repeat (3) step();
      check("span_pc0", last_pc, 32'h80);
`ifdef FROST_RVC_EN
      check("span_instr0", last_instr, 32'h0000_4501);
      step(); check("span_pc1", last_pc, 32'h82);
      check("span_instr1", last_instr, 32'h0000_0513);
      check("span_comp1", 32'(last_comp), 32'd0);
`else
      check("span_instr0", last_instr, 32'h0513_4501);
      step(); check("span_pc1", last_pc, 32'h84);
`endif

      // Consumer stall: the queue fills, fetch stops, the head instruction holds.
      i_instr_ready = 1'b0;
      repeat (10) begin
         step();
         check("stall_valid", 32'(last_valid), 32'd1);
      end
      check("stall_req_off", 32'(last_req), 32'd0);

      // Redirect to a halfword target while a response is arriving.
      i_instr_ready = 1'b1;
      n = 0;
      do begin step(); n++; end while (!last_req && n < 10);
      check("resp_inflight", 32'(last_req), 32'd1);
      redirect_to(32'h202);
      step(); check("half_req", 32'(last_req), 32'd1);
      check("half_req_addr", last_addr, 32'h200);
      step(); check("half_valid_early", 32'(last_valid), 32'd0);
      step(); check("half_valid", 32'(last_valid), 32'd1);
`ifdef FROST_RVC_EN
      check("half_pc", last_pc, 32'h202);
      check("half_instr", last_instr, 32'h0000_4505);
`else
      check("half_pc", last_pc, 32'h200);
      check("half_instr", last_instr, 32'h4505_4501);
`endif

      // Fetch address wraps at the top of the address space.
      redirect_to(32'hFFFF_FFFC);
      step(); check("wrap_addr0", last_addr, 32'hFFFF_FFFC);
      step(); check("wrap_req1", 32'(last_req), 32'd1);
      check("wrap_addr1", last_addr, 32'h0000_0000);

      // Random consumer backpressure and redirects.
      repeat (3000) begin
         i_instr_ready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 39) == 0) begin
            i_redirect = 1'b1;
            if ($urandom_range(0, 3) == 0) i_redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else                           i_redirect_pc = 32'($urandom_range(0, 32'h3FF));
         end else begin
            i_redirect = 1'b0;
         end
         step();
      end
      i_redirect = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
